ysyx_23060184_sram_resp: RTL and testbench
==========================================

# ysyx_23060184_sram_resp

AXI4-Lite responder modelling the data SRAM that the memory stage's load/store initiator and its arbiter drive. It accepts one read or one write transaction at a time, stores data in an internal word array, and returns the result after a programmable latency. It sits on the slave side of the SRAM arbiter port and drives the `s_*` handshake inputs of the memory stage.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `DEPTH_LOG2`, 12, log2 of word count (4096 words = 16 KiB).
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0.
- `FIXED_DELAY`, 1, wait cycles between address acceptance and response (0–15).

Ports:
- `clk` in 1: the single clock. `rst` in 1: reset, synchronous and active-high.
- `araddr` in 32, `arvalid` in 1, `aready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.

## Operation
- FSM states: IDLE, RWAIT, RRESP, WWAIT, BRESP.
- IDLE: `aready`=1. `awready`=`wready`=`awvalid & wvalid & ~arvalid`. AW and W are always accepted in the same cycle; a lone AW or lone W waits.
- Read has priority when `arvalid` and both write valids are high in the same cycle.
- AR handshake: latch `araddr` and load the delay counter, then go to RWAIT. AW+W handshake: latch addr, data and strobe, load the counter, then go to WWAIT.
- RWAIT/WWAIT: decrement the counter each cycle. At 0, go to RRESP or BRESP.
  - On the RRESP transition, capture `rdata` and `rresp`.
  - On the BRESP transition, commit the write (byte lane i written iff `wstrb[i]`) and set `bresp`.
- Address decode: word index = (addr − `BASE_ADDR`) >> 2. The low 2 bits are ignored.
  - In range: resp 2'b00.
  - Out of range: resp 2'b11 (DECERR). `rdata` = 32'h0 and no write occurs.
- RRESP: `rvalid`=1, with `rdata`/`rresp` held stable until `rready`. On handshake, return to IDLE.
- BRESP: `bvalid`=1 until `bready`. On handshake, return to IDLE.
- `aready`/`awready`/`wready` are 0 in every non-IDLE state, so there is no outstanding-transaction overlap.

## Timing
- AR handshake at cycle T with delay D: `rvalid` rises at T+1+D. D=0 gives a one-cycle read.
- Write: `bvalid` rises at T+1+D. Memory is updated at the same edge.
- The response handshake at cycle R puts the FSM in IDLE at R+1. The earliest next address acceptance is R+1.
- `rready`/`bready` may be held high before valid; the handshake completes in the first valid cycle.
- Reset is synchronous. While `rst`=1, the FSM is forced to IDLE and all outputs are 0, including `aready`/`awready`/`wready`. Outputs reset to: `rdata`=0, `rresp`=0, `bresp`=0, `rvalid`=0, `bvalid`=0, counter=0.
  - `aready` first reads 1 in the cycle after `rst` deasserts.
  - Reset mid-transaction drops the response. A pending write not yet committed is lost.
- Memory array contents are not reset.

## Configuration
- `YSYX_23060184_SRAM_RAND_DELAY_EN`:
  - Defined: the counter load value comes from the low 4 bits of a 16-bit LFSR (seed 16'hACE1 on reset, polynomial x^16+x^14+x^13+x^11+1). The LFSR advances one step per accepted transaction, and `FIXED_DELAY` is ignored.
  - Undefined: the load value is `FIXED_DELAY` and no LFSR is instantiated.

## Structure
- Shared defines header holds:
  - widths `DATA_WIDTH`, `ACERR_WIDTH` (2), `WMASK_LENGTH` (4);
  - resp codes OKAY=2'b00, DECERR=2'b11;
  - the FSM state encoding.
- Sub-module `ysyx_23060184_LFSR` (16-bit, enable + sync reset) is present only under the macro.

## Test plan
- Write `awaddr`=0x8000_0010, `wdata`=0xDEAD_BEEF, `wstrb`=4'hF, `bready`=1 → `bvalid` at T+2 (D=1), `bresp`=00.
  - Then read 0x8000_0010 → `rdata`=0xDEAD_BEEF, `rresp`=00, `rvalid` at T+2.
- Partial write `wstrb`=4'b0010, `wdata`=0x0000_5500 over 0xDEAD_BEEF → readback 0xDEAD_55EF.
- Read 0x7FFF_FFFC and 0x8001_0000 → `rresp`=2'b11, `rdata`=0.
  - Write to 0x8001_0000 → `bresp`=11, and memory is unchanged.
- `arvalid` plus `awvalid`/`wvalid` high in the same cycle → `aready`=1, `awready`=0. The read completes first, then the write is accepted in the cycle after the R handshake.
- Hold `rready`=0 for 5 cycles after `rvalid` → `rvalid`, `rdata` and `rresp` stay stable. `aready`=0 throughout.
- Assert `rst` during RWAIT → next cycle all outputs are 0. After release, `aready`=1 and no `rvalid` appears.
- With the macro defined: 100 back-to-back reads see varying latencies in 1..16 cycles, and all data is correct.

Source files
------------

// File: rtl/ysyx_23060184_sram_resp_pkg.sv
// ============================================================================
// Module : ysyx_23060184_sram_resp_pkg
// Brief  : Shared widths, AXI response codes and FSM state encoding for the
//          data-SRAM responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_23060184_sram_resp_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ACERR_WIDTH  = 2;
    localparam int WMASK_LENGTH = 4;
    localparam int DELAY_WIDTH  = 4;

    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [ACERR_WIDTH-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RWAIT = 3'd1,
        ST_RRESP = 3'd2,
        ST_WWAIT = 3'd3,
        ST_BRESP = 3'd4
    } state_t;

    // Response code for a decoded address: OKAY inside the array, DECERR outside.
    function automatic logic [ACERR_WIDTH-1:0] decode_resp(input logic in_range);
        return in_range ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060184_sram_resp_lfsr.sv
// ============================================================================
// Module : ysyx_23060184_LFSR
// Brief  : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with enable and
//          synchronous reset to a fixed seed. Supplies random response
//          latencies; only compiled when YSYX_23060184_SRAM_RAND_DELAY_EN
//          is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
module ysyx_23060184_LFSR #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    // Shift one step per enabled cycle; reseed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/ysyx_23060184_sram_resp.sv
// ============================================================================
// Module : ysyx_23060184_sram_resp
// Brief  : AXI4-Lite data-SRAM responder. One read or one write at a time,
//          word array storage, response after a programmable latency.
//          Optional macro YSYX_23060184_SRAM_RAND_DELAY_EN replaces the fixed
//          latency with a 4-bit LFSR-derived one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060184_sram_resp #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 12,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    FIXED_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    // read address channel
    input  logic [DATA_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    aready,
    // read data channel
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    // write address channel
    input  logic [DATA_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    // write response channel
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    import ysyx_23060184_sram_resp_pkg::*;

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NBYTES = DATA_WIDTH / 8;

    state_t                  state;
    logic                    aready_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NBYTES-1:0]       wstrb_q;
    logic [DELAY_WIDTH-1:0]  cnt;
    logic [DELAY_WIDTH-1:0]  delay;

    logic                    ar_hs;
    logic                    w_hs;
    logic [DATA_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   word_off;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [NBYTES-1:0]       sel_wstrb;
    logic                    commit;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Ready is registered so it only rises the cycle after reset releases;
    // gating with rst keeps it low for the whole reset window.
    assign aready  = aready_q & ~rst;
    assign ar_hs   = aready & arvalid;
    // AW and W are only taken together, and a pending read wins.
    assign w_hs    = aready & awvalid & wvalid & ~arvalid;
    assign awready = w_hs;
    assign wready  = w_hs;

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    ysyx_23060184_LFSR u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (ar_hs | w_hs),
        .q   (lfsr_q)
    );

    assign delay = lfsr_q[DELAY_WIDTH-1:0];
`else
    assign delay = DELAY_WIDTH'(FIXED_DELAY);
`endif

    // Address under decode: the live request in IDLE (zero-delay path),
    // otherwise the latched one.
    always_comb begin
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        sel_wstrb = wstrb_q;
        if (state == ST_IDLE) begin
            sel_addr  = arvalid ? araddr : awaddr;
            sel_wdata = wdata;
            sel_wstrb = wstrb;
        end
    end

    // Word offset from the base; anything beyond the array is DECERR.
    assign word_off = (sel_addr - BASE_ADDR) >> 2;
    assign in_range = (word_off >> DEPTH_LOG2) == '0;
    assign idx      = word_off[DEPTH_LOG2-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    // Write lands on the same edge that raises bvalid.
    assign commit = ~rst & ((w_hs && (delay == '0)) ||
                            ((state == ST_WWAIT) && (cnt == DELAY_WIDTH'(1))));

    // Byte-lane write into the array; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (sel_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= sel_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            aready_q <= 1'b0;
            rvalid   <= 1'b0;
            bvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            bresp    <= RESP_OKAY;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    aready_q <= 1'b1;
                    if (ar_hs) begin
                        aready_q <= 1'b0;
                        addr_q   <= araddr;
                        if (delay == '0) begin
                            state  <= ST_RRESP;
                            rvalid <= 1'b1;
                            rdata  <= rd_word;
                            rresp  <= decode_resp(in_range);
                        end else begin
                            state <= ST_RWAIT;
                            cnt   <= delay;
                        end
                    end else if (w_hs) begin
                        aready_q <= 1'b0;
                        addr_q   <= awaddr;
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        if (delay == '0) begin
                            state  <= ST_BRESP;
                            bvalid <= 1'b1;
                            bresp  <= decode_resp(in_range);
                        end else begin
                            state <= ST_WWAIT;
                            cnt   <= delay;
                        end
                    end
                end
                ST_RWAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DELAY_WIDTH'(1)) begin
                        state  <= ST_RRESP;
                        rvalid <= 1'b1;
                        rdata  <= rd_word;
                        rresp  <= decode_resp(in_range);
                    end
                end
                ST_RRESP: begin
                    if (rready) begin
                        state    <= ST_IDLE;
                        rvalid   <= 1'b0;
                        aready_q <= 1'b1;
                    end
                end
                ST_WWAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DELAY_WIDTH'(1)) begin
                        state  <= ST_BRESP;
                        bvalid <= 1'b1;
                        bresp  <= decode_resp(in_range);
                    end
                end
                ST_BRESP: begin
                    if (bready) begin
                        state    <= ST_IDLE;
                        bvalid   <= 1'b0;
                        aready_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    aready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060184_sram_resp.sv
// ============================================================================
// Module : tb_ysyx_23060184_sram_resp
// Brief  : Directed self-checking bench for the data-SRAM responder
//          (default build: fixed one-cycle wait, response two cycles after
//          the address handshake edge).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060184_sram_resp;

    localparam int LAT_EXP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        aready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    always #5 clk = ~clk;

    ysyx_23060184_sram_resp dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .aready  (aready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] dv,
                           output logic [1:0] rv, output int l);
        int k;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        #1;
        k = 0;
        while (!aready && k < 20) begin
            step();
            k++;
        end
        step();
        arvalid = 1'b0;
        l = 1;
        while (!rvalid && l < 40) begin
            step();
            l++;
        end
        dv = rdata;
        rv = rresp;
        step();
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] dat,
                            input logic [3:0] s, output logic [1:0] rv, output int l);
        int k;
        awaddr  = a;
        wdata   = dat;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        #1;
        k = 0;
        while (!awready && k < 20) begin
            step();
            k++;
        end
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        l = 1;
        while (!bvalid && l < 40) begin
            step();
            l++;
        end
        rv = bresp;
        step();
        bready = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b1; wdata = '0; wstrb = '0; wvalid = 1'b1; bready = 1'b0;

        // Reset state, with a write request pending at the inputs.
        step(); step(); step();
        chk("rst_aready",  aready,  0);
        chk("rst_awready", awready, 0);
        chk("rst_wready",  wready,  0);
        chk("rst_rvalid",  rvalid,  0);
        chk("rst_bvalid",  bvalid,  0);
        chk("rst_rdata",   rdata,   0);
        chk("rst_rresp",   rresp,   0);
        chk("rst_bresp",   bresp,   0);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("release_aready_same", aready, 0);
        step();
        chk("release_aready_next", aready, 1);

        // Full write then readback.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
        chk("wr_full_bresp", r, 2'b00);
        chk("wr_full_lat", lat, LAT_EXP);
        do_read(32'h8000_0010, d, r, lat);
        chk("rd_full_data", d, 32'hDEAD_BEEF);
        chk("rd_full_rresp", r, 2'b00);
        chk("rd_full_lat", lat, LAT_EXP);

        // Partial write, byte lane 1 only.
        do_write(32'h8000_0010, 32'h0000_5500, 4'b0010, r, lat);
        chk("wr_part_bresp", r, 2'b00);
        do_read(32'h8000_0010, d, r, lat);
        chk("rd_part_data", d, 32'hDEAD_55EF);

        // Low address bits are ignored.
        do_read(32'h8000_0013, d, r, lat);
        chk("rd_unaligned_data", d, 32'hDEAD_55EF);

        // Array edges: word 0 and last word.
        do_write(32'h8000_0000, 32'h1111_1111, 4'hF, r, lat);
        chk("wr_word0_bresp", r, 2'b00);
        do_write(32'h8000_3FFC, 32'h2222_3333, 4'hF, r, lat);
        chk("wr_last_bresp", r, 2'b00);
        do_read(32'h8000_3FFC, d, r, lat);
        chk("rd_last_data", d, 32'h2222_3333);
        chk("rd_last_rresp", r, 2'b00);

        // Out-of-range reads and write.
        do_read(32'h7FFF_FFFC, d, r, lat);
        chk("rd_below_rresp", r, 2'b11);
        chk("rd_below_data", d, 32'h0);
        do_read(32'h8001_0000, d, r, lat);
        chk("rd_above_rresp", r, 2'b11);
        chk("rd_above_data", d, 32'h0);
        do_read(32'h8000_4000, d, r, lat);
        chk("rd_justout_rresp", r, 2'b11);
        do_write(32'h8001_0000, 32'h1234_5678, 4'hF, r, lat);
        chk("wr_above_bresp", r, 2'b11);
        chk("wr_above_lat", lat, LAT_EXP);
        do_read(32'h8000_0000, d, r, lat);
        chk("rd_word0_untouched", d, 32'h1111_1111);
        do_read(32'h8000_0010, d, r, lat);
        chk("rd_0x10_untouched", d, 32'hDEAD_55EF);

        // Simultaneous read and write requests: read first.
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        chk("coll_aready", aready, 1);
        chk("coll_awready", awready, 0);
        chk("coll_wready", wready, 0);
        step();
        arvalid = 1'b0;
        #1;
        chk("coll_awready_busy", awready, 0);
        k = 0;
        while (!rvalid && k < 20) begin
            step();
            k++;
        end
        chk("coll_rdata", rdata, 32'hDEAD_55EF);
        chk("coll_awready_at_r", awready, 0);
        step();
        chk("coll_awready_after_r", awready, 1);
        chk("coll_wready_after_r", wready, 1);
        rready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 20) begin
            step();
            k++;
        end
        chk("coll_bvalid", bvalid, 1);
        chk("coll_bresp", bresp, 2'b00);
        step();
        bready = 1'b0;
        do_read(32'h8000_0020, d, r, lat);
        chk("coll_readback", d, 32'hCAFE_F00D);

        // Read backpressure: rready low for five cycles.
        araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin
            step();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'hCAFE_F00D);
            chk("bp_rresp", rresp, 2'b00);
            chk("bp_aready", aready, 0);
            step();
        end
        rready = 1'b1;
        step();
        chk("bp_rvalid_done", rvalid, 0);
        chk("bp_aready_done", aready, 1);
        rready = 1'b0;

        // Reset during RWAIT drops the read.
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        chk("rw_aready_wait", aready, 0);
        rst = 1'b1;
        step();
        chk("rw_rst_aready", aready, 0);
        chk("rw_rst_rvalid", rvalid, 0);
        chk("rw_rst_bvalid", bvalid, 0);
        chk("rw_rst_rdata", rdata, 0);
        chk("rw_rst_rresp", rresp, 0);
        chk("rw_rst_bresp", bresp, 0);
        rst = 1'b0;
        #1;
        chk("rw_release_aready_same", aready, 0);
        step();
        chk("rw_release_aready_next", aready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_rvalid", rvalid, 0);
            step();
        end
        rready = 1'b0;

        // Reset during WWAIT loses the uncommitted write.
        awaddr = 32'h8000_0010; wdata = 32'h0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        step();
        chk("ww_rst_bvalid", bvalid, 0);
        rst = 1'b0;
        bready = 1'b0;
        step();
        do_read(32'h8000_0010, d, r, lat);
        chk("ww_lost_data", d, 32'hDEAD_55EF);

`ifdef YSYX_23060184_SRAM_RAND_DELAY_EN
        begin
            int lmin;
            int lmax;
            lmin = 100;
            lmax = 0;
            for (int i = 0; i < 100; i++) begin
                do_read(32'h8000_0010, d, r, lat);
                chk("rand_data", d, 32'hDEAD_55EF);
                chk("rand_lat_range", 32'((lat >= 1) && (lat <= 16)), 1);
                if (lat < lmin) lmin = lat;
                if (lat > lmax) lmax = lat;
            end
            chk("rand_lat_varies", 32'(lmin != lmax), 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
